// File: rtl/ex_issue_stage.sv
// Execute-stage issue/retire unit: decodes opcodes into ALU op/operands, holds
// MUL ops for MUL_LAT cycles, and registers the ALU result with valid/ready backpressure.
module ex_issue_stage #(
  parameter int DSIZE   = 16,
  parameter int IMM_W   = 8,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [3:0]       in_rd,
  input  logic [DSIZE-1:0] in_rs_val,
  input  logic [DSIZE-1:0] in_rt_val,
  input  logic [IMM_W-1:0] in_imm,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [DSIZE-1:0] alu_out,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_we,
  output logic             out_branch
);
  // ALU op encodings, same order as the ADD..MUL macros
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3,
                         OP_SLL = 3'd4, OP_SRL = 3'd5, OP_COM = 3'd6, OP_MUL = 3'd7;
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef struct packed {
    logic             valid;
    logic [3:0]       opcode;
    logic [3:0]       rd;
    logic [DSIZE-1:0] a;
    logic [DSIZE-1:0] b;
    logic [CW-1:0]    cnt;
  } ex_t;

  ex_t ex;

  logic complete, writable, retire, accept, in_is_mul, in_is_imm;
  logic [DSIZE-1:0] imm_ext;

  assign complete  = ex.valid && (ex.cnt == '0);
  assign writable  = !out_valid || out_ready;
  assign retire    = complete && writable;
  assign in_ready  = !ex.valid || retire;
  assign accept    = in_valid && in_ready;
  assign in_is_mul = (in_opcode == 4'h7) || (in_opcode == 4'hD);
  assign in_is_imm = (in_opcode >= 4'h8) && (in_opcode <= 4'hD);
  assign imm_ext   = DSIZE'($signed(in_imm));

  assign alu_a = ex.a;
  assign alu_b = ex.b;

  always_comb begin
    alu_op = OP_ADD;
    if (!ex.opcode[3]) alu_op = ex.opcode[2:0];
    else begin
      case (ex.opcode)
        4'h8:    alu_op = OP_ADD;
        4'h9:    alu_op = OP_SUB;
        4'hA:    alu_op = OP_AND;
        4'hB:    alu_op = OP_XOR;
        4'hC:    alu_op = OP_SLL;
        4'hD:    alu_op = OP_MUL;
        4'hE:    alu_op = OP_SUB;
        default: alu_op = OP_ADD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex <= '0;
    end else if (accept) begin
      ex.valid  <= 1'b1;
      ex.opcode <= in_opcode;
      ex.rd     <= in_rd;
      ex.a      <= in_rs_val;
      ex.b      <= in_is_imm ? imm_ext : in_rt_val;
      ex.cnt    <= in_is_mul ? CW'(MUL_LAT - 1) : '0;
    end else begin
      if (retire) ex.valid <= 1'b0;
      if (ex.cnt != '0) ex.cnt <= ex.cnt - 1'b1;
    end
  end

  // A retire in the same cycle as a pop overwrites the old result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
      out_branch <= 1'b0;
    end else if (retire) begin
      out_valid  <= 1'b1;
      out_result <= alu_out;
      out_rd     <= ex.rd;
      out_we     <= (ex.opcode <= 4'hD);
      out_branch <= (ex.opcode == 4'hE) && alu_zero;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed bench for ex_issue_stage with a behavioural combinational ALU stub.
module tb_ex_issue_stage;
  localparam int DSIZE = 16, IMM_W = 8, MUL_LAT = 2;

  logic             clk = 0, rst = 1;
  logic             in_valid = 0, in_ready;
  logic [3:0]       in_opcode = 0, in_rd = 0;
  logic [DSIZE-1:0] in_rs_val = 0, in_rt_val = 0;
  logic [IMM_W-1:0] in_imm = 0;
  logic [DSIZE-1:0] alu_a, alu_b, alu_out;
  logic [2:0]       alu_op;
  logic             alu_zero;
  logic             out_valid, out_ready = 1, out_we, out_branch;
  logic [DSIZE-1:0] out_result;
  logic [3:0]       out_rd;
  int passed = 0, total = 0;

  ex_issue_stage #(.DSIZE(DSIZE), .IMM_W(IMM_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .out_branch(out_branch));

  always #5 clk = ~clk;

  // ALU stub: ADD SUB AND XOR SLL SRL COM MUL
  always_comb begin
    case (alu_op)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a ^ alu_b;
      3'd4: alu_out = alu_a << alu_b[3:0];
      3'd5: alu_out = alu_a >> alu_b[3:0];
      3'd6: alu_out = ~alu_a;
      default: alu_out = alu_a * alu_b;
    endcase
    alu_zero = (alu_a == alu_b);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd,
                       input logic [15:0] rs, input logic [15:0] rt, input logic [7:0] imm);
    in_valid = 1; in_opcode = op; in_rd = rd; in_rs_val = rs; in_rt_val = rt; in_imm = imm;
  endtask

  task automatic idle(input int n);
    in_valid = 0; out_ready = 1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    total++;
    if ({out_valid, out_result, out_rd, out_we, out_branch} !== '0)
      $display("FAIL reset_out got v=%b r=%h rd=%h we=%b br=%b want all 0",
               out_valid, out_result, out_rd, out_we, out_branch);
    else passed++;
    total++;
    if ({alu_a, alu_b, alu_op} !== '0)
      $display("FAIL reset_alu got a=%h b=%h op=%0d want 0/0/0", alu_a, alu_b, alu_op);
    else passed++;
    rst = 0; #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_add();
    drive(4'h0, 4'd3, 16'd5, 16'd7, 8'h00);
    tick();
    in_valid = 0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL add_early got out_valid=%b want 0", out_valid);
    else passed++;
    tick();
    total++;
    if ({out_valid, out_result, out_rd, out_we, out_branch} !== {1'b1, 16'd12, 4'd3, 1'b1, 1'b0})
      $display("FAIL add_result got v=%b r=%0d rd=%0d we=%b br=%b want 1/12/3/1/0",
               out_valid, out_result, out_rd, out_we, out_branch);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{4'h1, 4'hB, 4'hC, 4'h2};
    logic [15:0] rs  [4] = '{16'd9, 16'h00F0, 16'd1, 16'h0F0F};
    logic [15:0] rt  [4] = '{16'd4, 16'h0, 16'h0, 16'h00FF};
    logic [7:0]  imm [4] = '{8'h00, 8'h0F, 8'h03, 8'h00};
    logic [15:0] exp [4] = '{16'd5, 16'h00FF, 16'd8, 16'h000F};
    idle(2);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive(ops[i], 4'(i + 4), rs[i], rt[i], imm[i]);
        total++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready);
        else passed++;
      end else in_valid = 0;
      tick();
      if (i >= 1) begin
        total++;
        if ({out_valid, out_result, out_rd} !== {1'b1, exp[i-1], 4'(i + 3)})
          $display("FAIL b2b_result[%0d] got v=%b r=%h rd=%0d want 1/%h/%0d",
                   i - 1, out_valid, out_result, out_rd, exp[i-1], i + 3);
        else passed++;
      end
    end
  endtask

  task automatic test_mul();
    idle(2);
    drive(4'hD, 4'd1, 16'd6, 16'd0, 8'hFE);
    tick();
    total++;
    if (in_ready !== 1'b0) $display("FAIL mul_busy got in_ready=%b want 0", in_ready);
    else passed++;
    drive(4'h0, 4'd2, 16'd2, 16'd3, 8'h00);
    tick();
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL mul_complete got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else passed++;
    tick();
    in_valid = 0;
    total++;
    if ({out_valid, out_result, out_we} !== {1'b1, 16'hFFF4, 1'b1})
      $display("FAIL mul_result got v=%b r=%h we=%b want 1/fff4/1", out_valid, out_result, out_we);
    else passed++;
    tick();
    total++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 16'd5, 4'd2})
      $display("FAIL mul_follow got v=%b r=%0d rd=%0d want 1/5/2", out_valid, out_result, out_rd);
    else passed++;
  endtask

  task automatic test_beq();
    idle(2);
    drive(4'hE, 4'd7, 16'd10, 16'd10, 8'h00);
    tick();
    drive(4'hE, 4'd7, 16'd10, 16'd11, 8'h00);
    tick();
    in_valid = 0;
    total++;
    if ({out_valid, out_branch, out_we} !== 3'b110)
      $display("FAIL beq_taken got v=%b br=%b we=%b want 1/1/0", out_valid, out_branch, out_we);
    else passed++;
    tick();
    total++;
    if ({out_valid, out_branch, out_we} !== 3'b100)
      $display("FAIL beq_not_taken got v=%b br=%b we=%b want 1/0/0", out_valid, out_branch, out_we);
    else passed++;
    drive(4'hF, 4'd9, 16'd1, 16'd1, 8'h00);
    tick();
    in_valid = 0;
    tick();
    total++;
    if ({out_valid, out_branch, out_we} !== 3'b100)
      $display("FAIL nop got v=%b br=%b we=%b want 1/0/0", out_valid, out_branch, out_we);
    else passed++;
  endtask

  task automatic test_stall();
    idle(2);
    out_ready = 0;
    drive(4'h0, 4'd1, 16'd1, 16'd1, 8'h00);
    tick();
    drive(4'h0, 4'd2, 16'd3, 16'd4, 8'h00);
    tick();
    drive(4'h1, 4'd3, 16'd9, 16'd1, 8'h00);
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({out_valid, out_result, out_rd, alu_a, alu_b, alu_op, in_ready} !==
          {1'b1, 16'd2, 4'd1, 16'd3, 16'd4, 3'd0, 1'b0})
        $display("FAIL stall_hold[%0d] got v=%b r=%0d rd=%0d a=%0d b=%0d op=%0d rdy=%b want 1/2/1/3/4/0/0",
                 c, out_valid, out_result, out_rd, alu_a, alu_b, alu_op, in_ready);
      else passed++;
      if (c < 2) tick();
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    total++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 16'd7, 4'd2})
      $display("FAIL stall_drain0 got v=%b r=%0d rd=%0d want 1/7/2", out_valid, out_result, out_rd);
    else passed++;
    tick();
    total++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 16'd8, 4'd3})
      $display("FAIL stall_drain1 got v=%b r=%0d rd=%0d want 1/8/3", out_valid, out_result, out_rd);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL stall_empty got out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_mul();
    idle(2);
    out_ready = 0;
    drive(4'h0, 4'd5, 16'd20, 16'd22, 8'h00);
    tick();
    drive(4'h7, 4'd6, 16'd3, 16'd5, 8'h00);
    tick();
    in_valid = 0;
    tick();
    total++;
    if ({out_valid, out_result} !== {1'b1, 16'd42})
      $display("FAIL rstmul_pre got v=%b r=%0d want 1/42", out_valid, out_result);
    else passed++;
    rst = 1; #1;
    total++;
    if ({out_valid, out_result, out_rd, out_we, out_branch, alu_a, alu_b, alu_op} !== '0)
      $display("FAIL rstmul_async got v=%b r=%h rd=%h we=%b br=%b a=%h b=%h op=%0d want all 0",
               out_valid, out_result, out_rd, out_we, out_branch, alu_a, alu_b, alu_op);
    else passed++;
    #2 rst = 0; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({out_valid, in_ready} !== 2'b01)
        $display("FAIL rstmul_after[%0d] got v=%b rdy=%b want 0/1", c, out_valid, in_ready);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_beq();
    test_stall();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- Execute-stage issue/retire unit: sits between decode and the combinational ALU and acts as the ALU's initiator.
- Accepts decoded instructions on a valid/ready interface and maps each instruction opcode to an ALU op and operand pair.
- Holds multiply operations for a programmable number of cycles.
- Captures ALU out/zero into a registered result interface with its own valid/ready backpressure.

Parameters:
- DSIZE, 16, datapath width; must match the ALU's `DSIZE.
- IMM_W, 8, immediate field width; sign-extended to DSIZE.
- MUL_LAT, 2, cycles a MUL/MULI occupies the EX register (≥1); all other ops take 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  EX register can accept this cycle
- in_opcode  in  4  instruction opcode (encoding below)
- in_rd  in  4  destination register index
- in_rs_val  in  DSIZE  first source value
- in_rt_val  in  DSIZE  second source value
- in_imm  in  IMM_W  signed immediate
- alu_a  out  DSIZE  ALU operand a
- alu_b  out  DSIZE  ALU operand b
- alu_op  out  3  ALU op, using the `ADD..`MUL macros from define.v
- alu_out  in  DSIZE  ALU result (combinational)
- alu_zero  in  1  ALU a==b flag
- out_valid  out  1  result register valid
- out_ready  in  1  downstream accepts the result
- out_result  out  DSIZE  registered ALU result
- out_rd  out  4  destination index
- out_we  out  1  register write enable
- out_branch  out  1  BEQ taken

Behaviour:
- Opcode map:
  - 0x0-0x7 R-type, b = rt_val: ADD, SUB, AND, XOR, SLL, SRL, COM, MUL.
  - 0x8-0xD I-type, b = sext(imm): ADDI, SUBI, ANDI, XORI, SLLI, MULI.
  - 0xE BEQ: op SUB, b = rt_val, we=0, branch = alu_zero.
  - 0xF NOP: op ADD, we=0, branch=0.
- alu_a = EX.rs_val always; alu_op/alu_b are driven from the EX register only (never directly from the inputs).
- EX register: one entry holding {valid, opcode, rd, a, b, cnt}. Load on in_valid & in_ready.
  - cnt loads MUL_LAT-1 for MUL/MULI, else 0.
  - cnt decrements each cycle while nonzero.
- EX completes when EX.valid & cnt==0. The result register is writable when !out_valid | out_ready.
- Retire: complete & writable → the next edge loads out_result=alu_out, out_rd, out_we, out_branch, and sets out_valid=1.
- Stall: complete & !writable → EX holds; alu_a/alu_b/alu_op stay stable.
- in_ready = !EX.valid | (complete & writable). This is combinational and gives back-to-back acceptance for 1-cycle ops.
- Pop: out_valid & out_ready with no new retire → out_valid clears. Simultaneous pop and retire → the new result replaces the old one and out_valid stays 1.
- Latency: accept at edge N → out_valid high after edge N+1 (1-cycle op) or edge N+MUL_LAT (MUL). Throughput is 1/cycle for non-MUL ops.
- An instruction with in_valid & !in_ready is not consumed; the upstream stage holds its fields.
- NOP occupies a slot and produces out_valid with we=0, branch=0.
- Reset (asynchronous, any time including mid-MUL):
  - EX.valid=0, cnt=0, out_valid=0, out_result=0, out_rd=0, out_we=0, out_branch=0.
  - alu_a=0, alu_b=0, alu_op=`ADD.
  - in_ready=1 as soon as rst deasserts.
  - Any in-flight instruction is discarded.
- Width rules:
  - Immediates are sign-extended from IMM_W.
  - ALU result is truncated to DSIZE by the ALU; this block passes it through unmodified.

Test Plan:
- Reset then ADD rs=5, rt=7, rd=3, out_ready=1 → out_valid one cycle later with result=12, rd=3, we=1, branch=0.
- Four back-to-back ops (SUB 9-4, XORI 0xF0^sext(0x0F), SLLI 1<<3, AND) with out_ready=1 → in_ready stays 1; results 5, 0xFF, 8, ... on consecutive cycles, in order.
- MULI rs=6, imm=-2 (0xFE) with MUL_LAT=2 → in_ready low for one cycle; result 0xFFF4 two cycles after accept; a following ADD retires the next cycle.
- BEQ 10,10 then BEQ 10,11 → out_branch 1 then 0; out_we=0 for both.
- Hold out_ready=0 for 3 cycles after a result → out_valid and data stable; the next EX op stalls with stable alu_*; in_ready=0; releasing out_ready drains with no loss or duplication.
- Assert rst during the second MUL cycle → out_valid=0 and all outputs zero immediately (asynchronously); no result emitted after release.
